// File: rtl/uart_buffered.sv
// uart_buffered: 8N1 serial transmitter plus receiver with a small RX FIFO.
// Ports:
//   raw_clk, reset (async, active-low)
//   tx_data/tx_strobe in, tx_busy/tx_pin out      : transmit side
//   rx_pin in, rx_data/rx_ready out               : receive side, FIFO head
//   rx_ready_clear in                             : pop request (edge detected)
//   rx_overflow/rx_frame_error out                : sticky receive errors
module uart_buffered #(
    parameter int unsigned CLOCK_HZ      = 12000000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_strobe,
    output logic       tx_busy,
    output logic       tx_pin,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ready_clear,
    input  logic       rx_pin,
    output logic       rx_overflow,
    output logic       rx_frame_error
);

    localparam int unsigned DIV = CLOCK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam logic [CW-1:0] FULL_TICK = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_TICK = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t        tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic          tx_tick;
    logic          tx_pin_d;
    logic          tx_busy_d;

    assign tx_tick = (tx_cnt == FULL_TICK);

    // TX state register
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next state
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (tx_strobe) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tick) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    // TX outputs, registered below so the line level lags the state by one cycle
    always_comb begin
        tx_pin_d  = 1'b1;
        tx_busy_d = (tx_next != S_IDLE);
        case (tx_state)
            S_START: tx_pin_d = 1'b0;
            S_DATA:  tx_pin_d = tx_shift[tx_idx];
            default: tx_pin_d = 1'b1;
        endcase
    end

    // TX datapath: baud counter reloads on state entry, bit index, latched byte
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_pin   <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_cnt  <= (tx_next != tx_state || tx_tick || tx_state == S_IDLE) ? '0 : tx_cnt + CW'(1);
            if (tx_state != S_DATA) tx_idx <= '0;
            else if (tx_tick)       tx_idx <= tx_idx + 3'd1;
            if (tx_state == S_IDLE && tx_strobe) tx_shift <= tx_data;
            tx_pin  <= tx_pin_d;
            tx_busy <= tx_busy_d;
        end
    end

    // ---------------- receiver ----------------
    state_t        rx_state, rx_next;
    logic          rx_s1, rx_s, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_stop_done;
    logic          rx_tick, rx_half;
    logic          stop_sample, push_req, ferr_set, shift_en;

    assign rx_tick = (rx_cnt == FULL_TICK);
    assign rx_half = (rx_cnt == HALF_TICK);

    // Two-flop synchroniser plus previous value for falling-edge detection
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_pin;
            rx_s    <= rx_s1;
            rx_prev <= rx_s;
        end
    end

    // RX state register
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next state; STOP lingers until the line is high again
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = S_STOP;
            S_STOP:  if ((rx_stop_done || rx_tick) && rx_s) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    // RX outputs: sampling strobes derived from state and counter
    always_comb begin
        shift_en    = (rx_state == S_DATA) && rx_tick;
        stop_sample = (rx_state == S_STOP) && !rx_stop_done && rx_tick;
        push_req    = stop_sample && rx_s;
        ferr_set    = stop_sample && !rx_s;
    end

    // RX datapath
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_stop_done <= 1'b0;
        end else begin
            rx_cnt <= (rx_next != rx_state || rx_tick || rx_state == S_IDLE) ? '0 : rx_cnt + CW'(1);
            if (rx_state != S_DATA) rx_idx <= '0;
            else if (rx_tick)       rx_idx <= rx_idx + 3'd1;
            if (shift_en) rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_state != S_STOP) rx_stop_done <= 1'b0;
            else if (stop_sample)   rx_stop_done <= 1'b1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    mem [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          clr_q;
    logic          empty, full, pop, push, ovf_set;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop     = rx_ready_clear && !clr_q && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    assign rx_ready = !empty;
    assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Storage array, no reset needed
    always_ff @(posedge raw_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    // Pointers, pop edge detect, sticky error flags
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            clr_q          <= 1'b0;
            rx_overflow    <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            clr_q <= rx_ready_clear;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (ovf_set)  rx_overflow    <= 1'b1;
            if (ferr_set) rx_frame_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_buffered.sv
// Testbench for uart_buffered at DIV=16: directed stimulus, scoreboard queues
// checked by a TX line decoder and an RX pop monitor.
module tb_uart_buffered;

    logic       raw_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       tx_busy;
    logic       tx_pin;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ready_clear;
    logic       rx_pin;
    logic       rx_overflow;
    logic       rx_frame_error;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    uart_buffered #(.CLOCK_HZ(16), .BAUD(1), .RX_FIFO_DEPTH(4)) dut (
        .raw_clk        (raw_clk),
        .reset          (reset),
        .tx_data        (tx_data),
        .tx_strobe      (tx_strobe),
        .tx_busy        (tx_busy),
        .tx_pin         (tx_pin),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .rx_ready_clear (rx_ready_clear),
        .rx_pin         (rx_pin),
        .rx_overflow    (rx_overflow),
        .rx_frame_error (rx_frame_error)
    );

    always #5 raw_clk = ~raw_clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RX monitor: on each rising pop request while data is presented, compare head
    logic clr_last = 1'b0;
    always begin
        @(negedge raw_clk);
        if (rx_ready_clear && !clr_last && rx_ready) begin
            if (rx_exp.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_unexpected_byte: got 0x%0h, expected none", rx_data);
            end else begin
                check("rx_pop_data", int'(rx_data), int'(rx_exp.pop_front()));
            end
        end
        clr_last = rx_ready_clear;
    end

    // TX monitor: decode 8N1 frames from tx_pin; frames cut by reset are discarded
    logic       tx_last = 1'b1;
    logic       aborted;
    logic       start_lvl, stop_lvl;
    logic [7:0] tx_byte;
    always begin
        @(negedge raw_clk);
        if (reset === 1'b1 && tx_last && !tx_pin) begin
            aborted = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge raw_clk);
                if (!reset) aborted = 1'b1;
            end
            start_lvl = tx_pin;
            for (int i = 0; i < 8; i++) begin
                for (int k = 0; k < 16; k++) begin
                    @(negedge raw_clk);
                    if (!reset) aborted = 1'b1;
                end
                tx_byte[i] = tx_pin;
            end
            for (int k = 0; k < 16; k++) begin
                @(negedge raw_clk);
                if (!reset) aborted = 1'b1;
            end
            stop_lvl = tx_pin;
            if (!aborted) begin
                check("tx_start_bit", int'(start_lvl), 0);
                check("tx_stop_bit", int'(stop_lvl), 1);
                if (tx_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h, expected none", tx_byte);
                end else begin
                    check("tx_frame_byte", int'(tx_byte), int'(tx_exp.pop_front()));
                end
            end
        end
        tx_last = tx_pin;
    end

    // Drive one serial frame on rx_pin, 16 cycles per bit
    task automatic send(input logic [7:0] b, input logic stop_bit);
        @(posedge raw_clk);
        #1 rx_pin = 1'b0;
        repeat (16) @(posedge raw_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (16) @(posedge raw_clk);
            #1;
        end
        rx_pin = stop_bit;
        repeat (16) @(posedge raw_clk);
        #1;
        rx_pin = 1'b1;
        repeat (4) @(posedge raw_clk);
        #1;
    endtask

    task automatic pop_once();
        @(posedge raw_clk);
        #1 rx_ready_clear = 1'b1;
        repeat (2) @(posedge raw_clk);
        #1 rx_ready_clear = 1'b0;
        repeat (2) @(posedge raw_clk);
        #1;
    endtask

    int n, cnt, trans, bad, first_edge, lows;
    logic last_pin;

    initial begin
        reset          = 1'b0;
        tx_data        = 8'h00;
        tx_strobe      = 1'b0;
        rx_pin         = 1'b1;
        rx_ready_clear = 1'b0;
        repeat (3) @(posedge raw_clk);
        #1;
        check("rst_tx_pin", int'(tx_pin), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_rx_ready", int'(rx_ready), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_overflow", int'(rx_overflow), 0);
        check("rst_rx_frame_error", int'(rx_frame_error), 0);
        reset = 1'b1;

        // 1: reset mid-frame of 0xA5, while bit1 (low) is on the line
        @(posedge raw_clk);
        #1 tx_data = 8'hA5;
        tx_strobe = 1'b1;
        @(posedge raw_clk);
        #1 tx_strobe = 1'b0;
        repeat (40) @(posedge raw_clk);
        #1;
        check("abort_pin_before_reset", int'(tx_pin), 0);
        reset = 1'b0;
        #1;
        check("abort_tx_pin", int'(tx_pin), 1);
        check("abort_tx_busy", int'(tx_busy), 0);
        repeat (3) @(posedge raw_clk);
        #1 reset = 1'b1;
        lows = 0;
        repeat (150) begin
            @(negedge raw_clk);
            if (!tx_pin || tx_busy) lows++;
        end
        check("idle_after_reset", lows, 0);

        // 2: transmit 0x55, strobe held until busy; tx_data changed mid-frame
        @(posedge raw_clk);
        #1 tx_data = 8'h55;
        tx_strobe = 1'b1;
        tx_exp.push_back(8'h55);
        n = 0;
        while (!tx_busy && n < 10) begin
            @(posedge raw_clk);
            #1 n++;
        end
        check("busy_latency", n, 1);
        tx_strobe = 1'b0;
        tx_data   = 8'h00;
        cnt = 0; trans = 0; bad = 0; first_edge = -1;
        last_pin = tx_pin;
        while (tx_busy && cnt < 300) begin
            @(posedge raw_clk);
            #1 cnt++;
            if (tx_pin != last_pin) begin
                if (trans == 0) first_edge = cnt;
                if (cnt != 1 + 16 * trans) bad++;
                trans++;
                last_pin = tx_pin;
            end
        end
        check("strobe_to_start_edge", n + first_edge, 2);
        check("tx_level_changes", trans, 10);
        check("tx_level_misplaced", bad, 0);
        check("tx_busy_length", cnt, 160);
        repeat (20) @(posedge raw_clk);
        #1;

        // 3: receive 0xC3 then pop
        rx_exp.push_back(8'hC3);
        send(8'hC3, 1'b1);
        check("rx_ready_after_frame", int'(rx_ready), 1);
        check("rx_data_after_frame", int'(rx_data), 8'hC3);
        pop_once();
        check("rx_ready_after_pop", int'(rx_ready), 0);
        check("rx_data_after_pop", int'(rx_data), 0);

        // 6a: clear held high 40 cycles with 2 bytes queued pops exactly one
        rx_exp.push_back(8'h11);
        send(8'h11, 1'b1);
        rx_exp.push_back(8'h22);
        send(8'h22, 1'b1);
        @(posedge raw_clk);
        #1 rx_ready_clear = 1'b1;
        repeat (40) @(posedge raw_clk);
        #1 rx_ready_clear = 1'b0;
        @(posedge raw_clk);
        #1;
        check("held_clear_ready", int'(rx_ready), 1);
        check("held_clear_head", int'(rx_data), 8'h22);

        // 6b: fill FIFO, then pop in the same cycle as the next push
        rx_exp.push_back(8'h33);
        send(8'h33, 1'b1);
        rx_exp.push_back(8'h44);
        send(8'h44, 1'b1);
        rx_exp.push_back(8'h55);
        send(8'h55, 1'b1);
        rx_exp.push_back(8'h66);
        fork
            send(8'h66, 1'b1);
            begin
                repeat (155) @(posedge raw_clk);
                #1 rx_ready_clear = 1'b1;
            end
        join
        rx_ready_clear = 1'b0;
        check("full_push_pop_no_overflow", int'(rx_overflow), 0);
        check("full_push_pop_head", int'(rx_data), 8'h33);
        repeat (4) pop_once();
        check("drain_ready", int'(rx_ready), 0);

        // 4: five bytes without popping, fifth dropped
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) rx_exp.push_back(8'(i));
            send(8'(i), 1'b1);
        end
        check("overflow_set", int'(rx_overflow), 1);
        check("overflow_head", int'(rx_data), 8'h01);
        repeat (4) pop_once();
        check("overflow_drain_ready", int'(rx_ready), 0);
        check("overflow_drain_data", int'(rx_data), 0);

        // 5: 8-cycle glitch, then frame error, then recovery
        @(posedge raw_clk);
        #1 rx_pin = 1'b0;
        repeat (8) @(posedge raw_clk);
        #1 rx_pin = 1'b1;
        repeat (200) @(posedge raw_clk);
        #1;
        check("glitch_no_push", int'(rx_ready), 0);
        check("glitch_no_error", int'(rx_frame_error), 0);
        send(8'h7E, 1'b0);
        check("frame_error_set", int'(rx_frame_error), 1);
        check("frame_error_no_push", int'(rx_ready), 0);
        check("overflow_sticky", int'(rx_overflow), 1);
        rx_exp.push_back(8'h3C);
        send(8'h3C, 1'b1);
        check("recover_data", int'(rx_data), 8'h3C);
        pop_once();
        check("recover_drained", int'(rx_ready), 0);

        repeat (20) @(posedge raw_clk);
        #1;
        check("rx_scoreboard_left", rx_exp.size(), 0);
        check("tx_scoreboard_left", tx_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
